hdmi_pixfeed: RTL

- Single-clock pixel-source stage directly upstream of the HDMI pixel generator.
- Buffers a valid/ready pixel stream, tagged with start-of-frame and end-of-line flags, in a small synchronous FIFO.
- Serves one pixel per generator read strobe and aligns the stream to the generator's frame timing.
- Detects underflow and framing errors, then resynchronises automatically on the next start-of-frame.

---
 rtl/hdmi_pixfeed_pkg.sv | 22 ++
 rtl/hdmi_pixfeed_fifo.sv | 49 ++++
 rtl/hdmi_pixfeed.sv | 134 +++++++++++++
 3 files changed

// File: rtl/hdmi_pixfeed_pkg.sv
// Shared definitions for the HDMI pixel feeder: state encodings, default pixel
// width and FIFO entry field positions.
package hdmi_pixfeed_pkg;

    localparam int unsigned BPP_DEF = 24;

    typedef enum logic [1:0] {
        SYNC  = 2'b00,
        ARMED = 2'b01,
        RUN   = 2'b10
    } state_t;

    // Entry layout is {sof, last, pixel}
    function automatic int unsigned sof_bit(input int unsigned bpp);
        return bpp + 1;
    endfunction

    function automatic int unsigned last_bit(input int unsigned bpp);
        return bpp;
    endfunction

endpackage

// File: rtl/hdmi_pixfeed_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible combinationally.
module hdmi_pixfeed_fifo #(
    parameter int unsigned LGFIFO = 5,
    parameter int unsigned DW     = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     rdata_c,
    output logic              full_c,
    output logic              empty_c,
    output logic [LGFIFO:0]   fill
);

    localparam int unsigned DEPTH = 1 << LGFIFO;

    logic [DW-1:0]     mem [DEPTH];
    logic [LGFIFO-1:0] wr_ptr;
    logic [LGFIFO-1:0] rd_ptr;

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LGFIFO'(1);
            if (pop)  rd_ptr <= rd_ptr + LGFIFO'(1);
            case ({push, pop})
                2'b10:   fill <= fill + (LGFIFO+1)'(1);
                2'b01:   fill <= fill - (LGFIFO+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage carries no reset; contents are meaningless once the pointers clear
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata_c = mem[rd_ptr];
    assign full_c  = (fill == (LGFIFO+1)'(DEPTH));
    assign empty_c = (fill == '0);

endmodule

// File: rtl/hdmi_pixfeed.sv
// Pixel source for the HDMI generator: buffers the upstream stream, serves one
// pixel per read strobe and locks the stream to the generator's frame timing.
module hdmi_pixfeed
    import hdmi_pixfeed_pkg::*;
#(
    parameter int unsigned LGFIFO = 5,
    parameter int unsigned BPP    = BPP_DEF
) (
    input  logic              i_pixclk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [BPP-1:0]    i_pixel,
    input  logic              i_sof,
    input  logic              i_last,
    input  logic              i_rd,
    input  logic              i_newline,
    input  logic              i_newframe,
    output logic [BPP-1:0]    o_rgb_pix,
    output logic              o_locked,
    output logic              o_err,
    output logic [LGFIFO:0]   o_fill
);

    localparam int unsigned DW       = BPP + 2;
    localparam int unsigned DEPTH    = 1 << LGFIFO;
    localparam int unsigned SOF_POS  = sof_bit(BPP);
    localparam int unsigned LAST_POS = last_bit(BPP);

    logic [DW-1:0]    head;
    logic [DW-1:0]    wdata;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [LGFIFO:0]  fill_nxt;
    logic             head_sof;
    logic             head_last;

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             err_d;
    logic [BPP-1:0]   rgb_d;

    assign wdata     = {i_sof, i_last, i_pixel};
    assign push      = i_valid && o_ready && !full;
    assign head_sof  = head[SOF_POS];
    assign head_last = head[LAST_POS];
    assign fill_nxt  = o_fill + (LGFIFO+1)'(push) - (LGFIFO+1)'(pop);

    hdmi_pixfeed_fifo #(
        .LGFIFO (LGFIFO),
        .DW     (DW)
    ) u_fifo (
        .clk     (i_pixclk),
        .reset   (i_reset),
        .push    (push),
        .pop     (pop),
        .wdata   (wdata),
        .rdata_c (head),
        .full_c  (full),
        .empty_c (empty),
        .fill    (o_fill)
    );

    // Next state, pop decision and error detection
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        pop     = 1'b0;
        err_d   = 1'b0;
        rgb_d   = '0;
        case (state_q)
            SYNC: begin
                if (!empty) begin
                    if (head_sof) state_d = ARMED;
                    else          pop     = 1'b1;
                end
            end
            ARMED: begin
                if (i_newframe) begin
                    state_d = RUN;
                    first_d = 1'b1;
                end
            end
            RUN: begin
                if (i_rd) begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else if (head_sof && !first_q) begin
                        // SOF stays queued so SYNC can re-arm on it immediately
                        err_d = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        first_d = 1'b0;
                        last_d  = head_last;
                        rgb_d   = head[BPP-1:0];
                    end
                end
                // Newline is judged against the pixel popped this cycle, if any
                if (!err_d && i_newline && !last_d) err_d = 1'b1;
                if (!err_d && i_newframe) begin
                    if (!empty && head_sof) first_d = 1'b1;
                    else                    err_d   = 1'b1;
                end
                if (err_d) state_d = SYNC;
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge i_pixclk) begin
        if (i_reset) begin
            state_q   <= SYNC;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            o_rgb_pix <= '0;
            o_err     <= 1'b0;
            o_locked  <= 1'b0;
            o_ready   <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            last_q    <= last_d;
            o_rgb_pix <= rgb_d;
            o_err     <= err_d;
            o_locked  <= (state_d == RUN);
            o_ready   <= (fill_nxt != (LGFIFO+1)'(DEPTH));
        end
    end

endmodule
